// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package pipe_pkg;

  // Default bundle widths for the ID/EX use of the stage register
  localparam int CTRL_W_DEFAULT = 11;
  localparam int DATA_W_DEFAULT = 271;

  // Bit positions of the individual ID/EX control signals inside in_ctrl/out_ctrl
  localparam int ALUSRC    = 0;
  localparam int LDUR      = 1;
  localparam int MEM2REG   = 2;
  localparam int MEMWRITE  = 3;
  localparam int REGWRITE  = 4;
  localparam int SETFLAGS  = 5;
  localparam int IS_BR     = 6;
  localparam int BL        = 7;
  localparam int ALUOP_LSB = 8;
  localparam int ALUOP_MSB = 10;

  // Control bundle. Fields run MSB first, so the bit positions match the indices above.
  typedef struct packed {
    logic [2:0] aluop;
    logic       bl;
    logic       is_br;
    logic       setflags;
    logic       regwrite;
    logic       memwrite;
    logic       mem2reg;
    logic       ldur;
    logic       alusrc;
  } idex_ctrl_t;

  // Data bundle: three register indices plus four 64-bit words (PC and operands)
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] pc;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] imm;
  } idex_data_t;

  // True when the entry would change architectural state if it reached a later stage
  function automatic logic ctrl_has_side_effect(input idex_ctrl_t c);
    return c.regwrite | c.memwrite | c.setflags | c.bl;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry (valid + control + data) of the stage register.
// Latency: 1 cycle from load to the new value appearing on vld/ctrl/data.
// Backpressure: none inside the slot; the parent decides when to load or drop.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                  CTRL_W     = CTRL_W_DEFAULT,
  parameter int                  DATA_W     = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0]   RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,     // squash: invalidate and restore reset contents
  input  logic              load,      // capture ld_ctrl/ld_data and mark valid
  input  logic              drop,      // invalidate only; contents are kept
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_d,  vld_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next-state: clear beats load beats drop; contents only move on clear or load
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clear) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
      data_d = RESET_DATA;
    end else if (load) begin
      vld_d  = 1'b1;
      ctrl_d = ld_ctrl;
      data_d = ld_data;
    end else if (drop) begin
      vld_d  = 1'b0;
    end
  end

  // Slot registers; everything has a reset so nothing X leaks downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= RESET_DATA;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush (optional perf counters: PIPE_STAGE_PERF_EN).
// Latency: 1 cycle from accept to out_valid; full 1-per-cycle throughput while out_ready=1.
// Backpressure: in_ready is registered (= !skid_v), so a blocked main slot spills one entry into skid before stalling.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W     = CTRL_W_DEFAULT,
  parameter int                DATA_W     = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  input  logic              perf_clr
`endif
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              accept, drain;
  logic              main_load, main_drop;
  logic              skid_load, skid_drop;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic [DATA_W-1:0] main_src_data;

  // Handshake events and slot control. Skid always holds the younger entry,
  // so on a drain it has to move into main before anything new can.
  always_comb begin
    accept    = in_valid & in_ready;
    drain     = main_v & out_ready;
    // main refills from skid if skid is occupied, else from the input when main is free or leaving
    main_load = (skid_v & drain) | (accept & (~main_v | drain));
    main_drop = drain;
    // skid only fills when main is occupied and stays put this cycle
    skid_load = accept & main_v & ~drain;
    skid_drop = skid_v & drain;
    if (skid_v) begin
      main_src_ctrl = skid_ctrl;
      main_src_data = skid_data;
    end else begin
      main_src_ctrl = in_ctrl;
      main_src_data = in_data;
    end
  end

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .load    (main_load),
    .drop    (main_drop),
    .ld_ctrl (main_src_ctrl),
    .ld_data (main_src_data),
    .vld     (main_v),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .load    (skid_load),
    .drop    (skid_drop),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .vld     (skid_v),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  // Output side: control is gated so a bubble can never carry live write enables
  always_comb begin
    in_ready  = ~skid_v;
    out_valid = main_v;
    out_ctrl  = main_v ? main_ctrl : '0;
    out_data  = main_data;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] stall_cnt_d,  stall_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  // Saturating stall/bubble counters; clear wins over increment, flush is ignored
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (perf_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (main_v && !out_ready && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (!main_v && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus hand sequences, scoreboard on the output.
// Latency: checks outputs one cycle after each applied vector.
// Backpressure: driven through out_ready patterns in the vectors.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = CTRL_W_DEFAULT;
  localparam int DW = DATA_W_DEFAULT;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
  logic          perf_clr;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .perf_clr   (perf_clr)
`endif
  );

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic [15:0]   tag;
    logic [1:0]    occ;
    logic          rdy;
  } vec_t;

  ent_t          mq[$];       // scoreboard: entries the stage should hold, oldest first
  logic [DW-1:0] last_data;   // value out_data should hold while empty
  vec_t          vt[$];
  int            tests = 0;
  int            fails = 0;

  function automatic logic [DW-1:0] mk(input logic [15:0] t);
    return {t, 255'(t)};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [1:0] eocc, input logic erdy);
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ev = (mq.size() != 0);
    ec = ev ? mq[0].ctrl : '0;
    ed = ev ? mq[0].data : last_data;
    chk({nm, ".occupancy"}, DW'(occupancy), DW'(eocc));
    chk({nm, ".in_ready"},  DW'(in_ready),  DW'(erdy));
    chk({nm, ".out_valid"}, DW'(out_valid), DW'(ev));
    chk({nm, ".out_ctrl"},  DW'(out_ctrl),  DW'(ec));
    chk({nm, ".out_data"},  out_data,       ed);
  endtask

  // One cycle: drive at the current point, step the model at the edge, check on the next negedge
  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [CW-1:0] c,
                     input logic [15:0] tag, input logic [1:0] eocc, input logic erdy, input string nm);
    logic acc, drn;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_data   = mk(tag);
    acc = iv && !fl && (mq.size() < 2);
    drn = (mq.size() != 0) && ordy;
    @(posedge clk);
    if (drn) mq.delete(0);
    if (fl) mq.delete();
    else if (acc) mq.push_back('{ctrl: c, data: mk(tag)});
    if (fl) last_data = '0;
    else if (mq.size() != 0) last_data = mq[0].data;
    @(negedge clk);
    check_out(nm, eocc, erdy);
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic [CW-1:0] c,
                     input logic [15:0] tag, input logic [1:0] occ, input logic rdy);
    vt.push_back('{iv: iv, ordy: ordy, fl: fl, ctrl: c, tag: tag, occ: occ, rdy: rdy});
  endtask

  initial begin
    // Vector table: {in_valid, out_ready, flush, ctrl, tag} -> {occupancy, in_ready}
    for (int k = 1; k <= 8; k++) add(1, 1, 0, CW'(k * 37), 16'(k), 2'd1, 1'b1);  // streaming 1..8
    add(0, 1, 0, '0,      16'h0,  2'd0, 1'b1);
    add(1, 0, 0, 11'h123, 16'h0A, 2'd1, 1'b1);   // A into main
    add(1, 0, 0, 11'h234, 16'h0B, 2'd2, 1'b0);   // B into skid
    add(1, 0, 0, 11'h345, 16'h0C, 2'd2, 1'b0);   // C held upstream
    add(1, 1, 0, 11'h345, 16'h0C, 2'd1, 1'b1);   // A out, B moves to main, C still refused
    add(1, 1, 0, 11'h345, 16'h0C, 2'd1, 1'b1);   // B out, C accepted
    add(0, 1, 0, '0,      16'h0,  2'd0, 1'b1);   // C out
    add(1, 0, 0, 11'h0F1, 16'h0E, 2'd1, 1'b1);   // E
    add(1, 0, 0, 11'h0F2, 16'h0F, 2'd2, 1'b0);   // F
    add(1, 0, 1, 11'h0F3, 16'h0D, 2'd0, 1'b1);   // flush drops D
    add(0, 1, 0, '0,      16'h0,  2'd0, 1'b1);
    add(1, 0, 0, 11'h7FF, 16'h55, 2'd1, 1'b1);   // all-ones control
    add(0, 1, 0, '0,      16'h0,  2'd0, 1'b1);   // drained: ctrl gated, data retained
    add(0, 0, 0, '0,      16'h0,  2'd0, 1'b1);
    add(1, 0, 0, 11'h0AA, 16'h66, 2'd1, 1'b1);
    add(0, 1, 1, '0,      16'h0,  2'd0, 1'b1);   // drain and flush together
    add(0, 1, 0, '0,      16'h0,  2'd0, 1'b1);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    last_data = '0;
`ifdef PIPE_STAGE_PERF_EN
    perf_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_out("reset", 2'd0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      cyc(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].ctrl, vt[i].tag, vt[i].occ, vt[i].rdy,
          $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with both slots full
    cyc(1, 0, 0, 11'h301, 16'h71, 2'd1, 1'b1, "rst_fill0");
    cyc(1, 0, 0, 11'h302, 16'h72, 2'd2, 1'b0, "rst_fill1");
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    mq.delete();
    last_data = '0;
    #1 check_out("rst_async", 2'd0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 1, 0, '0, 16'h0, 2'd0, 1'b1, "rst_after");
    cyc(1, 1, 0, 11'h011, 16'h81, 2'd1, 1'b1, "rst_resume");
    cyc(0, 1, 0, '0, 16'h0, 2'd0, 1'b1, "rst_resume_drain");

`ifdef PIPE_STAGE_PERF_EN
    perf_clr = 1'b1;
    cyc(0, 0, 0, '0, 16'h0, 2'd0, 1'b1, "perf_clr0");
    perf_clr = 1'b0;
    chk("stall_clr0",  DW'(stall_cnt),  DW'(0));
    chk("bubble_clr0", DW'(bubble_cnt), DW'(0));
    cyc(1, 0, 0, 11'h001, 16'h91, 2'd1, 1'b1, "perf_fill");          // empty cycle: bubble 1
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, '0, 16'h0, 2'd1, 1'b1, "perf_stall");
    cyc(0, 1, 0, '0, 16'h0, 2'd0, 1'b1, "perf_drain");               // neither counter
    for (int k = 0; k < 2; k++) cyc(0, 0, 0, '0, 16'h0, 2'd0, 1'b1, "perf_empty");
    chk("stall_cnt",  DW'(stall_cnt),  DW'(5));
    chk("bubble_cnt", DW'(bubble_cnt), DW'(3));
    perf_clr = 1'b1;
    cyc(0, 0, 0, '0, 16'h0, 2'd0, 1'b1, "perf_clr1");
    perf_clr = 1'b0;
    chk("stall_clr1",  DW'(stall_cnt),  DW'(0));
    chk("bubble_clr1", DW'(bubble_cnt), DW'(0));
    cyc(1, 0, 0, 11'h002, 16'h92, 2'd1, 1'b1, "perf_fill2");
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, '0, 16'h0, 2'd1, 1'b1, "perf_sat");
    chk("stall_sat", DW'(stall_cnt), DW'(32'hFFFF_FFFF));
    cyc(0, 1, 0, '0, 16'h0, 2'd0, 1'b1, "perf_end");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed per-field ID/EX-style registers.
- Carries one control bundle and one data bundle between any two CPU stages, with a valid/ready handshake, a 2-entry skid buffer (full throughput under backpressure) and synchronous flush for branch/exception squash.
- Control fields are forced to zero whenever the stage holds no valid entry, so RegWrite, MemWrite and similar controls can never fire from a bubble.

Parameters:
- CTRL_W, 11, width of the control bundle (zeroed on bubble/flush).
- DATA_W, 271, width of the data bundle (3×5-bit register indices + 4×64-bit operands/PC).
- RESET_DATA, 0, reset/flush value of the data bundle (DATA_W bits).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts the entry this cycle
- out_ctrl  out  CTRL_W  control bundle; 0 when out_valid=0
- out_data  out  DATA_W  data bundle; holds last value when out_valid=0
- flush  in  1  synchronous squash of all held entries
- occupancy  out  2  number of entries held (0..2)

Behaviour:
- Reset: while reset_n=0, asynchronously clear main_v and skid_v, so out_valid=0, occupancy=0 and in_ready=1. out_ctrl=0 and out_data=RESET_DATA. Reset asserted mid-transfer discards all entries, with no partial state.
- Storage: a main slot drives the outputs; a skid slot captures an entry accepted while the main slot is blocked.
- in_ready is registered and equals !skid_v. It does not depend combinationally on out_ready.
- Accept occurs when in_valid & in_ready. Drain occurs when out_valid & out_ready.
- Transitions per cycle (occupancy states EMPTY/ONE/TWO):
  - EMPTY + accept → ONE; the entry goes to main and is visible the next cycle (latency 1).
  - ONE + accept + drain → ONE, with the new entry in main.
  - ONE + accept, no drain → TWO, with the new entry in skid.
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE; skid moves to main and skid_v clears. No accept is possible because in_ready=0.
  - TWO, no drain → hold all state.
- Ordering is strictly FIFO. Throughput is 1 entry per cycle while out_ready=1.
- out_ctrl = main_v ? main_ctrl : 0 (combinational gating after the register).
- Flush has priority over every other event in that cycle:
  - next state is EMPTY, in_ready=1 the next cycle, and main/skid data are set to RESET_DATA;
  - an in_valid presented in the flush cycle is dropped;
  - a drain in the flush cycle still completes, because downstream sampled it.
- Data slots load only on accept or skid→main move, so no toggling on idle cycles.
- occupancy = main_v + skid_v.
- No X propagation: control registers have reset; data slots also have reset, to RESET_DATA.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, add these ports:
  - stall_cnt  out  32  counts cycles with out_valid & !out_ready
  - bubble_cnt  out  32  counts cycles with !out_valid
  - perf_clr  in  1  synchronous clear of both counters, with priority over increment
- Both counters saturate at 32'hFFFF_FFFF, reset to 0 and are not affected by flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - localparams for the control-bit indices (ALUSRC, LDUR, MEM2REG, MEMWRITE, REGWRITE, SETFLAGS, IS_BR, BL, ALUOP[2:0]);
  - CTRL_W_DEFAULT=11 and DATA_W_DEFAULT=271;
  - a packed struct typedef for the ID/EX control bundle, so users cast in_ctrl/out_ctrl.
- One sub-module, pipe_slot: a single valid+ctrl+data entry with load, clear and async reset. It is instantiated twice, as main and skid.

Test Plan:
- Reset: assert reset_n=0 mid-stream with occupancy=2 → outputs go immediately to out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 → out_data 1..8 on cycles 1..8, in_ready held at 1, occupancy=1.
- Backpressure: feed A,B,C while out_ready=0 from cycle 1 → A in main, B in skid, in_ready=0, C held upstream. Then raise out_ready=1 → output order A,B,C with no loss or duplication.
- Flush: occupancy=2 with in_valid=1 (entry D), pulse flush → next cycle occupancy=0, out_ctrl=0, D dropped, in_ready=1.
- Bubble gating: in_ctrl=11'h7FF accepted then drained, with no new input → out_valid=0 and out_ctrl=0 while out_data retains its last value.
- With PIPE_STAGE_PERF_EN: 5 stall cycles then 3 empty cycles → stall_cnt=5, bubble_cnt=3. Pulse perf_clr → both read 0 the next cycle. Preload a counter to near-max via force → saturates at FFFF_FFFF.
